// File: rtl/bg_index_fetch.sv
// rtl/bg_index_fetch.sv - background ROM index fetch with frame-synchronous scrolling
// Optional vertical scroll: define BG_VSCROLL_EN.
module bg_index_fetch #(
    parameter int BG_W        = 320,
    parameter int BG_H        = 240,
    parameter int SCALE_SHIFT = 1,
    parameter int ADDR_W      = 17,
    parameter int IDX_W       = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              pixel_valid,
    input  logic              frame_start,
    input  logic [8:0]        scroll_x_req,
`ifdef BG_VSCROLL_EN
    input  logic [8:0]        scroll_y_req,
`endif
    input  logic              scroll_req_valid,
    output logic              scroll_req_ready,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_data,
    output logic [IDX_W-1:0]  index,
    output logic              index_valid,
    output logic [9:0]        DrawX_out,
    output logic [9:0]        DrawY_out
);

    typedef enum logic {S_IDLE, S_PENDING} state_t;
    state_t state;

    logic [8:0]        scroll_x_active;
    logic [8:0]        scroll_x_pending;
    logic [9:0]        bx_sum;
    logic [9:0]        bx;
    logic [9:0]        by;
    logic              blank;
    logic [ADDR_W-1:0] addr_next;
    logic              v1, v2;
    logic [9:0]        x1, y1, x2, y2;

`ifdef BG_VSCROLL_EN
    logic [8:0] scroll_y_active;
    logic [8:0] scroll_y_pending;
    logic [9:0] by_sum;
`endif

    always_comb begin
        bx_sum = (DrawX >> SCALE_SHIFT) + {1'b0, scroll_x_active};
        bx     = (bx_sum >= 10'(BG_W)) ? bx_sum - 10'(BG_W) : bx_sum;
`ifdef BG_VSCROLL_EN
        by_sum = (DrawY >> SCALE_SHIFT) + {1'b0, scroll_y_active};
        by     = (by_sum >= 10'(BG_H)) ? by_sum - 10'(BG_H) : by_sum;
`else
        by_sum_unused_guard();
        by     = DrawY >> SCALE_SHIFT;
`endif
        blank     = !pixel_valid || (by >= 10'(BG_H));
        addr_next = ADDR_W'(by) * ADDR_W'(BG_W) + ADDR_W'(bx);
    end

`ifndef BG_VSCROLL_EN
    function automatic void by_sum_unused_guard();
    endfunction
`endif

    // Scroll requests are parked until frame_start so a frame never tears.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state            <= S_IDLE;
            scroll_req_ready <= 1'b0;
            scroll_x_active  <= '0;
            scroll_x_pending <= '0;
`ifdef BG_VSCROLL_EN
            scroll_y_active  <= '0;
            scroll_y_pending <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    scroll_req_ready <= 1'b1;
                    if (scroll_req_valid && scroll_req_ready) begin
                        scroll_x_pending <= (scroll_x_req >= 9'(BG_W)) ?
                                            scroll_x_req - 9'(BG_W) : scroll_x_req;
`ifdef BG_VSCROLL_EN
                        scroll_y_pending <= (scroll_y_req >= 9'(BG_H)) ?
                                            scroll_y_req - 9'(BG_H) : scroll_y_req;
`endif
                        scroll_req_ready <= 1'b0;
                        state            <= S_PENDING;
                    end
                end
                S_PENDING: begin
                    scroll_req_ready <= 1'b0;
                    if (frame_start) begin
                        scroll_x_active  <= scroll_x_pending;
`ifdef BG_VSCROLL_EN
                        scroll_y_active  <= scroll_y_pending;
`endif
                        scroll_req_ready <= 1'b1;
                        state            <= S_IDLE;
                    end
                end
                default: begin
                    scroll_req_ready <= 1'b0;
                    state            <= S_IDLE;
                end
            endcase
        end
    end

    // Three-stage pipeline: address, ROM access, index capture.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            rom_addr    <= '0;
            v1          <= 1'b0;
            v2          <= 1'b0;
            x1          <= '0;
            y1          <= '0;
            x2          <= '0;
            y2          <= '0;
            index       <= '0;
            index_valid <= 1'b0;
            DrawX_out   <= '0;
            DrawY_out   <= '0;
        end else begin
            rom_addr    <= blank ? '0 : addr_next;
            v1          <= !blank;
            x1          <= DrawX;
            y1          <= DrawY;
            v2          <= v1;
            x2          <= x1;
            y2          <= y1;
            index       <= v2 ? rom_data : '0;
            index_valid <= v2;
            DrawX_out   <= x2;
            DrawY_out   <= y2;
        end
    end

endmodule

// File: tb/tb_bg_index_fetch.sv
// tb/tb_bg_index_fetch.sv - directed self-checking bench for bg_index_fetch
module tb_bg_index_fetch;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [9:0]  DrawX, DrawY;
    logic        pixel_valid, frame_start;
    logic [8:0]  scroll_x_req;
`ifdef BG_VSCROLL_EN
    logic [8:0]  scroll_y_req;
`endif
    logic        scroll_req_valid, scroll_req_ready;
    logic [16:0] rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  index;
    logic        index_valid;
    logic [9:0]  DrawX_out, DrawY_out;

    int n_vec = 0;
    int n_err = 0;

    bg_index_fetch dut (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .pixel_valid(pixel_valid), .frame_start(frame_start),
        .scroll_x_req(scroll_x_req),
`ifdef BG_VSCROLL_EN
        .scroll_y_req(scroll_y_req),
`endif
        .scroll_req_valid(scroll_req_valid), .scroll_req_ready(scroll_req_ready),
        .rom_addr(rom_addr), .rom_data(rom_data), .index(index),
        .index_valid(index_valid), .DrawX_out(DrawX_out), .DrawY_out(DrawY_out)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] rom_model(input logic [16:0] a);
        return (a == 17'd645) ? 8'h0E : (a[7:0] ^ 8'hA5);
    endfunction

    always_ff @(posedge Clk) rom_data <= rom_model(rom_addr);

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        Reset_n = 1'b0; DrawX = 10'd123; DrawY = 10'd7; pixel_valid = 1'b1;
        frame_start = 1'b1; scroll_x_req = 9'd77; scroll_req_valid = 1'b1;
`ifdef BG_VSCROLL_EN
        scroll_y_req = 9'd0;
`endif
        // T1 reset
        tick(); tick(); tick();
        chk("rst_addr", rom_addr, 0);
        chk("rst_index", index, 0);
        chk("rst_ivalid", index_valid, 0);
        chk("rst_xout", DrawX_out, 0);
        chk("rst_yout", DrawY_out, 0);
        chk("rst_ready", scroll_req_ready, 0);
        Reset_n = 1'b1; scroll_req_valid = 1'b0; frame_start = 1'b0; pixel_valid = 1'b0;
        tick();
        chk("rel_ready", scroll_req_ready, 1);

        // T2 latency
        DrawX = 10'd10; DrawY = 10'd4; pixel_valid = 1'b1;
        tick();
        chk("t2_addr", rom_addr, 645);
        pixel_valid = 1'b0;
        tick(); tick();
        chk("t2_index", index, 8'h0E);
        chk("t2_ivalid", index_valid, 1);
        chk("t2_xout", DrawX_out, 10);
        chk("t2_yout", DrawY_out, 4);

        // T5 blanking
        tick(); tick(); tick();
        chk("t5_addr_inv", rom_addr, 0);
        chk("t5_index_inv", index, 0);
        chk("t5_ivalid_inv", index_valid, 0);
        DrawX = 10'd20; DrawY = 10'd490; pixel_valid = 1'b1;
        tick();
        chk("t5_addr_by", rom_addr, 0);
        tick(); tick();
        chk("t5_index_by", index, 0);
        chk("t5_ivalid_by", index_valid, 0);
        chk("t5_yout_by", DrawY_out, 490);

        // T3 wrap with scroll 100, committed at frame_start
        scroll_x_req = 9'd100; scroll_req_valid = 1'b1;
        tick();
        chk("t3_ready_drop", scroll_req_ready, 0);
        scroll_req_valid = 1'b0;
        DrawX = 10'd600; DrawY = 10'd10;
        tick();
        chk("t3_addr_old", rom_addr, 5*320+300);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("t3_ready_back", scroll_req_ready, 1);
        chk("t3_addr_fs_edge", rom_addr, 5*320+300);
        tick();
        chk("t3_addr_wrap", rom_addr, 5*320+80);
        tick(); tick();
        chk("t3_index", index, rom_model(17'd1680));
        chk("t3_xout", DrawX_out, 600);

        // T4 request on frame_start cycle waits for the following frame_start
        scroll_x_req = 9'd50; scroll_req_valid = 1'b1; frame_start = 1'b1;
        tick();
        scroll_req_valid = 1'b0; frame_start = 1'b0;
        chk("t4_ready_drop", scroll_req_ready, 0);
        DrawX = 10'd0; DrawY = 10'd0;
        tick();
        chk("t4_addr_old", rom_addr, 100);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        chk("t4_addr_new", rom_addr, 50);

        // back-to-back requests; 400 reduces to 80
        scroll_x_req = 9'd400; scroll_req_valid = 1'b1;
        tick();
        scroll_x_req = 9'd10;
        tick();
        chk("b2b_stall", scroll_req_ready, 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("b2b_ready", scroll_req_ready, 1);
        tick();
        chk("b2b_addr80", rom_addr, 80);
        chk("b2b_accept2", scroll_req_ready, 0);
        scroll_req_valid = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        chk("b2b_addr10", rom_addr, 10);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        chk("fs_nopend", rom_addr, 10);

        // reset mid-frame then refill
        Reset_n = 1'b0;
        tick();
        chk("mid_rst_addr", rom_addr, 0);
        chk("mid_rst_index", index, 0);
        chk("mid_rst_ready", scroll_req_ready, 0);
        Reset_n = 1'b1; DrawX = 10'd10; DrawY = 10'd4;
        tick();
        chk("refill_ready", scroll_req_ready, 1);
        chk("refill_addr", rom_addr, 645);
        tick(); tick();
        chk("refill_index", index, 8'h0E);
        chk("refill_ivalid", index_valid, 1);

`ifdef BG_VSCROLL_EN
        // T6 vertical wrap: by = 20 + 230 - 240 = 10
        scroll_x_req = 9'd0; scroll_y_req = 9'd230; scroll_req_valid = 1'b1;
        tick();
        scroll_req_valid = 1'b0; frame_start = 1'b1;
        tick();
        frame_start = 1'b0; DrawX = 10'd0; DrawY = 10'd40;
        tick();
        chk("t6_addr", rom_addr, 10*320);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
